// File: rtl/vga_timing_if.sv
// itf_vga: raster timing bus between the timing generator and the draw pipeline.
interface itf_vga;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_timing.sv
// vga_timing: free-running XGA 1024x768@60 raster counters, strobes and start-of-frame pulse.
module vga_timing #(
    parameter int H_TOTAL   = 1344,
    parameter int H_B_START = 1024,
    parameter int H_S_START = 1048,
    parameter int H_S_END   = 1184,
    parameter int V_TOTAL   = 806,
    parameter int V_B_START = 768,
    parameter int V_S_START = 771,
    parameter int V_S_END   = 777
) (
    input  logic    clk,
    input  logic    rst,
    itf_vga.master  out,
    output logic    new_frame
);
    logic [10:0] h_nxt;
    logic [10:0] v_nxt;
    logic        h_wrap;
    logic        v_wrap;

    always_comb begin
        h_wrap = out.hcount == 11'(H_TOTAL - 1);
        v_wrap = out.vcount == 11'(V_TOTAL - 1);
        h_nxt  = h_wrap ? 11'd0 : out.hcount + 11'd1;
        v_nxt  = !h_wrap ? out.vcount : v_wrap ? 11'd0 : out.vcount + 11'd1;
    end

    // Strobes decode the next counter values so they line up with the counters they describe.
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
            new_frame  <= 1'b0;
        end else begin
            out.hcount <= h_nxt;
            out.vcount <= v_nxt;
            out.hblnk  <= h_nxt >= 11'(H_B_START);
            out.hsync  <= h_nxt >= 11'(H_S_START) && h_nxt < 11'(H_S_END);
            out.vblnk  <= v_nxt >= 11'(V_B_START);
            out.vsync  <= v_nxt >= 11'(V_S_START) && v_nxt < 11'(V_S_END);
            out.rgb    <= '0;
            new_frame  <= h_wrap && v_wrap;
        end
endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: full-size instance for reset/line boundaries, scaled instance for frame-level behaviour.
module tb_vga_timing;
    localparam int SH = 20, SHB = 12, SHS = 14, SHE = 17;
    localparam int SV = 10, SVB = 6, SVS = 7, SVE = 8;

    typedef struct {
        int unsigned cyc;
        bit          sel;
        logic [38:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_a, rst_b;
    logic nf_a, nf_b;
    int unsigned cyc = 0;
    int checks = 0;
    int failures = 0;
    longint last_nf = -1;
    exp_t q[$];

    itf_vga bus_a();
    itf_vga bus_b();

    vga_timing dut_a (.clk(clk), .rst(rst_a), .out(bus_a), .new_frame(nf_a));
    vga_timing #(.H_TOTAL(SH), .H_B_START(SHB), .H_S_START(SHS), .H_S_END(SHE),
                 .V_TOTAL(SV), .V_B_START(SVB), .V_S_START(SVS), .V_S_END(SVE))
        dut_b (.clk(clk), .rst(rst_b), .out(bus_b), .new_frame(nf_b));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [38:0] pk(int h, int v, bit hs, bit vs, bit hb, bit vb, bit nf);
        return {11'(h), 11'(v), hs, vs, hb, vb, nf, 12'h000};
    endfunction

    function automatic exp_t model(int unsigned c, int p);
        exp_t e;
        int h = p % SH;
        int v = (p / SH) % SV;
        e.cyc  = c;
        e.sel  = 1'b1;
        e.val  = pk(h, v, h >= SHS && h < SHE, v >= SVS && v < SVE, h >= SHB, v >= SVB,
                    p > 0 && p % (SH * SV) == 0);
        e.name = "small_model";
        return e;
    endfunction

    task automatic push(exp_t e);
        int i = 0;
        while (i < q.size() && q[i].cyc <= e.cyc) i++;
        q.insert(i, e);
    endtask

    task automatic push_zero(bit sel, int unsigned c, string name);
        exp_t e;
        e.cyc = c; e.sel = sel; e.val = '0; e.name = name;
        push(e);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Monitor: pops expectations due this cycle, plus per-cycle range and frame-spacing checks.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic [38:0] act;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            act = e.sel ? {bus_b.hcount, bus_b.vcount, bus_b.hsync, bus_b.vsync, bus_b.hblnk, bus_b.vblnk, nf_b, bus_b.rgb}
                        : {bus_a.hcount, bus_a.vcount, bus_a.hsync, bus_a.vsync, bus_a.hblnk, bus_a.vblnk, nf_a, bus_a.rgb};
            checks++;
            if (e.cyc != cyc || act !== e.val) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", e.name, cyc, act, e.val);
            end
        end
        if (rst_b === 1'b1) begin
            checks++;
            if (!(bus_b.hcount < 11'(SH) && bus_b.vcount < 11'(SV))) begin
                failures++;
                $display("FAIL range cyc=%0d got h=%0d v=%0d", cyc, bus_b.hcount, bus_b.vcount);
            end
        end
        if (nf_b === 1'b1) begin
            if (last_nf >= 0) begin
                checks++;
                if (longint'(cyc) - last_nf != SH * SV) begin
                    failures++;
                    $display("FAIL nf_spacing got=%0d exp=%0d", longint'(cyc) - last_nf, SH * SV);
                end
            end
            last_nf = cyc;
        end
    end

    initial begin
        int unsigned base_a, base_b, c0;
        int tbl[11][5] = '{
            '{1,    1,    0, 0, 0}, '{1023, 1023, 0, 0, 0}, '{1024, 1024, 0, 0, 1},
            '{1047, 1047, 0, 0, 1}, '{1048, 1048, 0, 1, 1}, '{1183, 1183, 0, 1, 1},
            '{1184, 1184, 0, 0, 1}, '{1343, 1343, 0, 0, 1}, '{1344, 0,    1, 0, 0},
            '{1345, 1,    1, 0, 0}, '{2688, 0,    2, 0, 0}};
        exp_t e;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) step();
        push_zero(0, cyc, "reset_a");
        push_zero(1, cyc, "reset_b");
        rst_a = 1'b1;
        rst_b = 1'b1;
        base_b = cyc;
        for (int p = 0; p < 485; p++) push(model(base_b + p, p));
        // Mid-frame reset of the scaled instance on line 4.
        while (cyc < base_b + 485) step();
        rst_b = 1'b0;
        last_nf = -1;
        for (int k = 0; k < 3; k++) push_zero(1, cyc + k, "midframe_rst");
        repeat (3) step();
        rst_b = 1'b1;
        c0 = cyc;
        for (int p = 0; p < 451; p++) push(model(c0 + p, p));
        // Full-size instance: 3-clock reset mid-line, then line boundaries.
        while (cyc < base_b + 500) step();
        rst_a = 1'b0;
        for (int k = 0; k < 3; k++) push_zero(0, cyc + k, "rst_hold");
        repeat (3) step();
        rst_a = 1'b1;
        base_a = cyc;
        push_zero(0, base_a, "post_release");
        for (int i = 0; i < 11; i++) begin
            e.cyc  = base_a + tbl[i][0];
            e.sel  = 1'b0;
            e.val  = pk(tbl[i][1], tbl[i][2], tbl[i][3] != 0, 1'b0, tbl[i][4] != 0, 1'b0, 1'b0);
            e.name = $sformatf("line_p%0d", tbl[i][0]);
            push(e);
        end
        for (int i = 0; i < 6000 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            failures++;
            $display("FAIL timeout pending=%0d exp=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
